uart_tx_scheduler: RTL and testbench

- Shares one UART transmit line (data_t) between NREQ byte requesters, e.g. key echo, score report and game-over banner.
- Round-robin arbiter grants one requester per frame, latches its byte, and serializes it as 8N1 at BAUD.
- Baud timing is derived internally from clk; this block replaces any free-running divided clock on the TX side.
- Sits beside the keyboard UART receiver at the top level.

---
 rtl/uart_tx_pkg.sv | 23 ++
 rtl/uart_tx_scheduler_if.sv | 23 ++
 rtl/uart_tx_scheduler_rr_arbiter.sv | 38 +++
 rtl/uart_tx_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_pkg.sv
// ----------------------------------------------------------------------------
// uart_tx_pkg
// Shared types and constants for the UART transmit scheduler.
//   state_t    : serializer FSM states (IDLE -> START -> DATA -> STOP)
//   FRAME_BITS : bit slots in one 8N1 frame (start + 8 data + stop)
//   bit_cycles : clock cycles per bit slot for a given clock and line rate
// ----------------------------------------------------------------------------
package uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int FRAME_BITS = 10;

    function automatic int bit_cycles(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// ----------------------------------------------------------------------------
// uart_tx_scheduler_if
// Request/grant and serial-line bundle between the byte requesters and the
// UART transmit scheduler.
//   req    : per-requester byte pending (held with data stable until gnt)
//   data   : byte for requester i at bits [8i+7:8i]
//   gnt    : one-hot single-cycle grant; the byte is latched in that cycle
//   data_t : serial TX line, idle high
//   busy   : frame in progress
// master = requester side, slave = scheduler side.
// ----------------------------------------------------------------------------
interface uart_tx_scheduler_if #(
    parameter int NREQ = 3
);
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] data;
    logic [NREQ-1:0]   gnt;
    logic              data_t;
    logic              busy;

    modport master (output req, data, input gnt, data_t, busy);
    modport slave  (input req, data, output gnt, data_t, busy);
endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: first set request searching upward from
// the pointer with wrap-around. The pointer register lives in the user.
//   i_req   : request vector
//   i_ptr   : index to search from (highest priority this round)
//   o_grant : one-hot winner (zero when no request)
//   o_idx   : binary index of the winner
//   o_valid : any request present
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int NREQ = 3,
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [PW-1:0]   o_idx,
    output logic            o_valid
);

    always_comb begin
        int k;
        k       = 0;
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int o = 0; o < NREQ; o++) begin
            k = (int'(i_ptr) + o) % NREQ;
            if (!o_valid && i_req[k]) begin
                o_valid    = 1'b1;
                o_grant[k] = 1'b1;
                o_idx      = PW'(k);
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// ----------------------------------------------------------------------------
// uart_tx_scheduler
// Shares one 8N1 UART transmit line between NREQ byte requesters. A
// round-robin arbiter picks one requester per frame; its byte is latched and
// shifted out LSB first at BAUD, with bit timing derived from clk.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of uart_tx_scheduler_if (req/data in; gnt/data_t/busy out)
// Timing: gnt is high for one cycle in IDLE, the start bit begins the next
// cycle, busy covers exactly FRAME_BITS*BIT_CYCLES cycles.
// ----------------------------------------------------------------------------
module uart_tx_scheduler
    import uart_tx_pkg::*;
#(
    parameter int CLK_HZ = 100000000,
    parameter int BAUD   = 9600,
    parameter int NREQ   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_tx_scheduler_if.slave bus
);

    localparam int BIT_CYCLES = bit_cycles(CLK_HZ, BAUD);
    localparam int CW         = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int PW         = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int DATA_BITS  = FRAME_BITS - 2;

    state_t          r_state;
    logic [CW-1:0]   r_baud_cnt;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_gidx;
    logic [NREQ-1:0] r_gnt;
    logic            r_data_t;
    logic            r_busy;

    state_t          w_state_nxt;
    logic [CW-1:0]   w_baud_nxt;
    logic [2:0]      w_bit_nxt;
    logic [7:0]      w_shift_nxt;
    logic [PW-1:0]   w_ptr_nxt;
    logic [PW-1:0]   w_gidx_nxt;
    logic [NREQ-1:0] w_gnt_nxt;
    logic            w_data_t_nxt;
    logic            w_busy_nxt;
    logic            w_decide;
    logic            w_baud_last;
    logic            w_bit_last;
    logic [7:0]      w_sel_byte;

    logic [NREQ-1:0] w_arb_grant;
    logic [PW-1:0]   w_arb_idx;
    logic            w_arb_valid;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .i_req   (bus.req),
        .i_ptr   (r_ptr),
        .o_grant (w_arb_grant),
        .o_idx   (w_arb_idx),
        .o_valid (w_arb_valid)
    );

    // Byte of the requester granted last cycle.
    always_comb begin
        w_sel_byte = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_gidx == PW'(i)) begin
                w_sel_byte = bus.data[8*i +: 8];
            end
        end
    end

    assign w_baud_last = (r_baud_cnt == CW'(BIT_CYCLES - 1));
    assign w_bit_last  = (r_bit_cnt == 3'(DATA_BITS - 1));

    always_comb begin
        w_state_nxt  = r_state;
        w_baud_nxt   = r_baud_cnt;
        w_bit_nxt    = r_bit_cnt;
        w_shift_nxt  = r_shift;
        w_ptr_nxt    = r_ptr;
        w_gidx_nxt   = r_gidx;
        w_gnt_nxt    = '0;
        w_decide     = 1'b0;
        w_data_t_nxt = 1'b1;
        w_busy_nxt   = 1'b0;

        unique case (r_state)
            IDLE: begin
                // A grant issued last edge means this is the gnt cycle:
                // latch the byte now and start the frame next cycle.
                if (r_gnt != '0) begin
                    w_shift_nxt = w_sel_byte;
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = START;
                end else begin
                    w_decide = 1'b1;
                end
            end
            START: begin
                if (w_baud_last) begin
                    w_baud_nxt  = '0;
                    w_state_nxt = DATA;
                end else begin
                    w_baud_nxt = r_baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (w_baud_last) begin
                    w_baud_nxt  = '0;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (w_bit_last) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = STOP;
                    end else begin
                        w_bit_nxt = r_bit_cnt + 1'b1;
                    end
                end else begin
                    w_baud_nxt = r_baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (w_baud_last) begin
                    w_baud_nxt  = '0;
                    w_state_nxt = IDLE;
                    // Arbitrate on the last stop cycle so the grant pulse
                    // lands in the first IDLE cycle.
                    w_decide    = 1'b1;
                end else begin
                    w_baud_nxt = r_baud_cnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        if (w_decide && w_arb_valid) begin
            w_gnt_nxt  = w_arb_grant;
            w_gidx_nxt = w_arb_idx;
            w_ptr_nxt  = (w_arb_idx == PW'(NREQ - 1)) ? '0 : w_arb_idx + 1'b1;
        end

        // Line level is registered from the next state so it never glitches.
        unique case (w_state_nxt)
            START:   w_data_t_nxt = 1'b0;
            DATA:    w_data_t_nxt = w_shift_nxt[0];
            default: w_data_t_nxt = 1'b1;
        endcase
        w_busy_nxt = (w_state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_ptr      <= '0;
            r_gidx     <= '0;
            r_gnt      <= '0;
            r_data_t   <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_ptr      <= w_ptr_nxt;
            r_gidx     <= w_gidx_nxt;
            r_gnt      <= w_gnt_nxt;
            r_data_t   <= w_data_t_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    assign bus.gnt    = r_gnt;
    assign bus.data_t = r_data_t;
    assign bus.busy   = r_busy;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_scheduler
// Directed bench for uart_tx_scheduler with CLK_HZ=16, BAUD=1 (16 cycles per
// bit) and three requesters. Expected grants/bytes go into a scoreboard when
// requests are driven; a line monitor decodes frames and the main sequence
// pops and compares them.
// ----------------------------------------------------------------------------
module tb_uart_tx_scheduler;

    localparam int NREQ = 3;
    localparam int BC   = 16;
    localparam int FRM  = 10 * BC;

    typedef struct {
        logic [2:0] g;
        logic [7:0] b;
    } exp_t;

    typedef struct {
        logic [7:0] b;
        logic       ok;
        int         start;
        logic       busy_after;
    } obs_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;

    exp_t       exp_q[$];
    logic [7:0] byte_q[$];
    int         gcyc_q[$];
    obs_t       obs_q[$];

    uart_tx_scheduler_if #(.NREQ(NREQ)) bus ();

    uart_tx_scheduler #(
        .CLK_HZ (16),
        .BAUD   (1),
        .NREQ   (NREQ)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Frame decoder: samples every falling edge, checks each bit slot is
    // constant, busy high throughout, and the line idle-high afterwards.
    initial begin
        int         ms;
        int         p;
        int         st;
        logic [7:0] sh;
        logic       ok;
        logic       lvl;
        ms = 0; p = 0; st = 0; sh = '0; ok = 1'b0; lvl = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ms = 0;
            end else begin
                case (ms)
                    0: if (bus.data_t === 1'b0) begin
                        ms  = 1;
                        p   = 0;
                        st  = cyc;
                        sh  = '0;
                        lvl = 1'b0;
                        ok  = (bus.busy === 1'b1);
                    end
                    1: begin
                        p++;
                        if (p % BC == 0) lvl = bus.data_t;
                        if (bus.data_t !== lvl || bus.busy !== 1'b1) ok = 1'b0;
                        if (p % BC == BC / 2) begin
                            if (p / BC == 0 && bus.data_t !== 1'b0) ok = 1'b0;
                            if (p / BC == 9 && bus.data_t !== 1'b1) ok = 1'b0;
                            if (p / BC >= 1 && p / BC <= 8) sh[p / BC - 1] = bus.data_t;
                        end
                        if (p == FRM - 1) ms = 2;
                    end
                    default: begin
                        if (bus.data_t !== 1'b1) ok = 1'b0;
                        obs_q.push_back('{sh, ok, st, bus.busy});
                        ms = 0;
                    end
                endcase
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Waits (bounded) for the next grant, compares it with the scoreboard
    // head, then steps one cycle and checks the pulse has ended.
    task automatic wait_grant(input int limit, output int gcyc);
        exp_t e;
        int   n;
        n    = 0;
        gcyc = -1;
        e    = exp_q.pop_front();
        while (bus.gnt == '0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("gnt", 32'(bus.gnt), 32'(e.g));
        if (bus.gnt != '0) begin
            gcyc = cyc;
            byte_q.push_back(e.b);
            gcyc_q.push_back(cyc);
        end
        @(negedge clk);
        chk("gnt_pulse", 32'(bus.gnt), 32'(0));
    endtask

    task automatic check_frame(input int limit, output int start);
        obs_t       o;
        logic [7:0] eb;
        int         eg;
        int         n;
        n     = 0;
        start = -1;
        while (obs_q.size() == 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (obs_q.size() == 0) begin
            chk("frame_timeout", 32'(obs_q.size()), 32'(1));
        end else begin
            o  = obs_q.pop_front();
            eb = byte_q.pop_front();
            eg = gcyc_q.pop_front();
            start = o.start;
            chk("frame_byte", 32'(o.b), 32'(eb));
            chk("frame_shape", 32'(o.ok), 32'(1));
            chk("start_latency", 32'(o.start), 32'(eg + 1));
            chk("busy_after", 32'(o.busy_after), 32'(0));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int g1;
        int g2;
        int g3;
        int s;
        int sprev;
        int extra;
        int n;

        bus.req  = '0;
        bus.data = '0;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_data_t", 32'(bus.data_t), 32'(1));
        chk("rst_gnt", 32'(bus.gnt), 32'(0));
        chk("rst_busy", 32'(bus.busy), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Single request
        bus.data = 24'h0000A5;
        bus.req  = 3'b001;
        exp_q.push_back('{3'b001, 8'hA5});
        wait_grant(400, g1);
        bus.req = '0;
        check_frame(400, s);

        // Data change one cycle after grant
        bus.data = 24'h0000A5;
        bus.req  = 3'b001;
        exp_q.push_back('{3'b001, 8'hA5});
        wait_grant(400, g1);
        bus.data[7:0] = 8'hFF;
        bus.req       = '0;
        check_frame(400, s);

        // Contention from a reset pointer
        do_reset();
        bus.data = 24'h332211;
        bus.req  = 3'b111;
        exp_q.push_back('{3'b001, 8'h11});
        exp_q.push_back('{3'b010, 8'h22});
        exp_q.push_back('{3'b100, 8'h33});
        exp_q.push_back('{3'b001, 8'h11});
        for (int i = 0; i < 4; i++) begin
            wait_grant(400, g1);
        end
        bus.req = '0;
        sprev = 0;
        for (int i = 0; i < 4; i++) begin
            check_frame(400, s);
            if (i > 0) chk("start_spacing", 32'(s - sprev), 32'(FRM + 1));
            sprev = s;
        end

        // Fairness wrap: grant req1 (pointer -> 2), then req 011 goes to req0
        bus.data = 24'h00C33C;
        bus.req  = 3'b010;
        exp_q.push_back('{3'b010, 8'hC3});
        wait_grant(400, g1);
        bus.req = 3'b011;
        exp_q.push_back('{3'b001, 8'h3C});
        exp_q.push_back('{3'b010, 8'hC3});
        wait_grant(400, g2);
        bus.req = 3'b010;
        wait_grant(400, g3);
        bus.req = '0;
        chk("wrap_gap", 32'(g2 - g1), 32'(FRM + 1));
        chk("rr_gap", 32'(g3 - g2), 32'(FRM + 1));
        for (int i = 0; i < 3; i++) check_frame(400, s);

        // Request raised mid-frame
        bus.data = 24'h00C3A5;
        bus.req  = 3'b001;
        exp_q.push_back('{3'b001, 8'hA5});
        wait_grant(400, g1);
        bus.req = '0;
        repeat (80) @(negedge clk);
        bus.req = 3'b010;
        exp_q.push_back('{3'b010, 8'hC3});
        extra = 0;
        n     = 0;
        while (bus.busy === 1'b1 && n < 400) begin
            if (bus.gnt != '0) extra++;
            @(negedge clk);
            n++;
        end
        chk("busy_no_gnt", 32'(extra), 32'(0));
        chk("idle_gnt", 32'(bus.gnt), 32'(3'b010));
        wait_grant(400, g2);
        bus.req = '0;
        chk("busy_req_gap", 32'(g2 - g1), 32'(FRM + 1));
        check_frame(400, s);
        check_frame(400, s);

        // Reset during data bit 3
        bus.data = 24'h5A00A5;
        bus.req  = 3'b001;
        exp_q.push_back('{3'b001, 8'hA5});
        wait_grant(400, g1);
        bus.req = '0;
        repeat (4 * BC + BC / 2) @(negedge clk);
        chk("pre_reset_bit3", 32'(bus.data_t), 32'(0));
        #2 rst_n = 1'b0;
        #1;
        chk("arst_data_t", 32'(bus.data_t), 32'(1));
        chk("arst_busy", 32'(bus.busy), 32'(0));
        chk("arst_gnt", 32'(bus.gnt), 32'(0));
        void'(byte_q.pop_front());
        void'(gcyc_q.pop_front());
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        bus.req = 3'b100;
        exp_q.push_back('{3'b100, 8'h5A});
        wait_grant(400, g1);
        bus.req = '0;
        check_frame(400, s);
        chk("no_stray_frame", 32'(obs_q.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
